// File: rtl/add_group_seq_if.sv
// -----------------------------------------------------------------------------
// add_group_seq_if
// Request/response bundle for add_group_seq.
//
// Handshake: a request is taken on a rising clk_p edge where addend_valid_n is
// low and addend_ready is high. Operands and mode_sub only need to be stable
// at that edge. The result strobe sum_valid_n is low for exactly one cycle per
// accepted request, and sum holds its value until the next result.
//
// Signals
//   addend1, addend2 : packed signed operands, element k at [k*IW +: IW]
//   mode_sub         : 0 add, 1 subtract (addend1 - addend2)
//   addend_valid_n   : active-low request
//   addend_ready     : request can be accepted
//   sum              : packed result, element k at [k*OW +: OW]
//   sum_valid_n      : active-low one-cycle result strobe
// Modports: master drives requests, slave is the adder group.
// -----------------------------------------------------------------------------
interface add_group_seq_if #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH + 1,
    parameter int NUM_ELEM     = 64
);
    logic [INPUT_WIDTH*NUM_ELEM-1:0]  addend1;
    logic [INPUT_WIDTH*NUM_ELEM-1:0]  addend2;
    logic                             mode_sub;
    logic                             addend_valid_n;
    logic                             addend_ready;
    logic [OUTPUT_WIDTH*NUM_ELEM-1:0] sum;
    logic                             sum_valid_n;

    modport master (
        output addend1, addend2, mode_sub, addend_valid_n,
        input  addend_ready, sum, sum_valid_n
    );

    modport slave (
        input  addend1, addend2, mode_sub, addend_valid_n,
        output addend_ready, sum, sum_valid_n
    );
endinterface

// File: rtl/add_group_seq.sv
// -----------------------------------------------------------------------------
// add_group_seq
// Time-multiplexed element-wise add/sub of two packed signed vectors. NUM_LANE
// physical adders are reused over NUM_BEAT = NUM_ELEM/NUM_LANE beats; the whole
// result vector is published at once with a one-cycle active-low strobe.
//
// Ports
//   clk_p       : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : add_group_seq_if.slave (operands, handshake, result)
//   dbg_state_o : current FSM state (0 IDLE, 1 RUN)
//
// Optional feature: define ADD_GROUP_SAT_EN to clamp every element result to
// the INPUT_WIDTH signed range before it is staged.
// -----------------------------------------------------------------------------
module add_group_seq #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH + 1,
    parameter int NUM_ELEM     = 64,
    parameter int NUM_LANE     = 16
) (
    input  logic              clk_p,
    input  logic              rst_n,
    add_group_seq_if.slave    bus,
    output logic              dbg_state_o
);
    localparam int IW       = INPUT_WIDTH;
    localparam int OW       = OUTPUT_WIDTH;
    localparam int NUM_BEAT = NUM_ELEM / NUM_LANE;
    localparam int BW       = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1;
    localparam int IDXW     = $clog2(NUM_ELEM) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [IW*NUM_ELEM-1:0] op1_q, op1_d;
    logic [IW*NUM_ELEM-1:0] op2_q, op2_d;
    logic                  sub_q, sub_d;
    logic [OW*NUM_ELEM-1:0] stage_q, stage_d;
    logic [OW*NUM_ELEM-1:0] sum_q, sum_d;
    logic                  sum_valid_n_q, sum_valid_n_d;

    logic [IDXW-1:0]        lane_idx [NUM_LANE];
    logic signed [OW-1:0]   lane_res [NUM_LANE];

    // Lane g always works on element beat*NUM_LANE + g of the latched operands.
    for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
        logic signed [OW-1:0] ea, eb, raw;
        assign lane_idx[g] = IDXW'(beat_q) * IDXW'(NUM_LANE) + IDXW'(g);
        assign ea  = {{(OW-IW){op1_q[lane_idx[g]*IW + IW-1]}}, op1_q[lane_idx[g]*IW +: IW]};
        assign eb  = {{(OW-IW){op2_q[lane_idx[g]*IW + IW-1]}}, op2_q[lane_idx[g]*IW +: IW]};
        assign raw = sub_q ? (ea - eb) : (ea + eb);
`ifdef ADD_GROUP_SAT_EN
        localparam logic signed [OW-1:0] SAT_MAX = {{(OW-IW+1){1'b0}}, {(IW-1){1'b1}}};
        localparam logic signed [OW-1:0] SAT_MIN = {{(OW-IW+1){1'b1}}, {(IW-1){1'b0}}};
        assign lane_res[g] = (raw > SAT_MAX) ? SAT_MAX :
                             (raw < SAT_MIN) ? SAT_MIN : raw;
`else
        assign lane_res[g] = raw;
`endif
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        sub_d         = sub_q;
        stage_d       = stage_q;
        sum_d         = sum_q;
        sum_valid_n_d = 1'b1;

        if (state_q == IDLE) begin
            if (!bus.addend_valid_n) begin
                op1_d   = bus.addend1;
                op2_d   = bus.addend2;
                sub_d   = bus.mode_sub;
                beat_d  = '0;
                state_d = RUN;
            end
        end else begin
            for (int i = 0; i < NUM_LANE; i++) begin
                stage_d[lane_idx[i]*OW +: OW] = lane_res[i];
            end
            beat_d = beat_q + 1'b1;
            // stage_d already carries the final beat's slice, so the whole
            // vector is published on this edge.
            if (beat_q == BW'(NUM_BEAT - 1)) begin
                sum_d         = stage_d;
                sum_valid_n_d = 1'b0;
                beat_d        = '0;
                state_d       = IDLE;
            end
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            sub_q         <= 1'b0;
            stage_q       <= '0;
            sum_q         <= '0;
            sum_valid_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            sub_q         <= sub_d;
            stage_q       <= stage_d;
            sum_q         <= sum_d;
            sum_valid_n_q <= sum_valid_n_d;
        end
    end

    assign bus.addend_ready = (state_q == IDLE);
    assign bus.sum          = sum_q;
    assign bus.sum_valid_n  = sum_valid_n_q;
    assign dbg_state_o      = state_q;
endmodule
